// File: rtl/tinycpu_stack.sv
// Parametrised operand stack: single-cycle PUSH/POP/DUP/SWAP/REPL/BINOP/CLEAR with
// occupancy count, full/empty decode and sticky overflow/underflow flags.
module tinycpu_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] qtop,
  output logic [WIDTH-1:0] qnext,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpPush  = 3'b001;
  localparam logic [2:0] OpPop   = 3'b010;
  localparam logic [2:0] OpDup   = 3'b011;
  localparam logic [2:0] OpSwap  = 3'b100;
  localparam logic [2:0] OpRepl  = 3'b101;
  localparam logic [2:0] OpBinop = 3'b110;
  localparam logic [2:0] OpClear = 3'b111;

  // mem_q[0] is the bottom entry; the top lives at index count_q-1.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovf_err, unf_err;

  logic             is_full, is_empty, has_two;
  logic [AW-1:0]    idx_free, idx_top, idx_next;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign has_two  = (count_q >= CW'(2));
  assign idx_free = AW'(count_q);
  assign idx_top  = AW'(count_q - CW'(1));
  assign idx_next = AW'(count_q - CW'(2));

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovf_err = 1'b0;
    unf_err = 1'b0;
    unique case (op)
      OpNop: ;
      OpPush: begin
        if (is_full) begin
          ovf_err = 1'b1;
        end else begin
          mem_d[idx_free] = din;
          count_d         = count_q + CW'(1);
        end
      end
      OpPop: begin
        if (is_empty) unf_err = 1'b1;
        else          count_d = count_q - CW'(1);
      end
      OpDup: begin
        // Underflow takes priority over overflow (only matters when DEPTH is 0-sized).
        if (is_empty) begin
          unf_err = 1'b1;
        end else if (is_full) begin
          ovf_err = 1'b1;
        end else begin
          mem_d[idx_free] = mem_q[idx_top];
          count_d         = count_q + CW'(1);
        end
      end
      OpSwap: begin
        if (!has_two) begin
          unf_err = 1'b1;
        end else begin
          mem_d[idx_top]  = mem_q[idx_next];
          mem_d[idx_next] = mem_q[idx_top];
        end
      end
      OpRepl: begin
        if (is_empty) unf_err = 1'b1;
        else          mem_d[idx_top] = din;
      end
      OpBinop: begin
        if (!has_two) begin
          unf_err = 1'b1;
        end else begin
          mem_d[idx_next] = din;
          count_d         = count_q - CW'(1);
        end
      end
      OpClear: count_d = '0;
      default: ;
    endcase
    // A new error wins over a coincident clear request.
    ovf_d = ovf_err | (ovf_q & ~clr_err);
    unf_d = unf_err | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry contents beyond count are don't-care, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= mem_d;
    end
  end

  assign qtop  = is_empty ? '0 : mem_q[idx_top];
  assign qnext = has_two  ? mem_q[idx_next] : '0;
  assign count = count_q;
  assign full  = is_full;
  assign empty = is_empty;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule
